// File: rtl/nbit_shift_pkg.sv
// nbit_shift_pkg: op and state encodings shared by the sequential shifter
package nbit_shift_pkg;

    typedef enum logic [2:0] {
        OP_ROR = 3'b000,
        OP_ROL = 3'b001,
        OP_SRL = 3'b010,
        OP_SLL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nbit_step_shift.sv
// nbit_step_shift: moves data by k positions (k <= STEP) and reports the last bit moved out
module nbit_step_shift
    import nbit_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   k,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             bit_out
);

    logic [WIDTH-1:0] rr, rl;
    logic [SHW-1:0]   lo, hi;

    assign rr = (data >> k) | (data << (WIDTH - int'(k)));
    assign rl = (data << k) | (data >> (WIDTH - int'(k)));
    assign lo = k - SHW'(1);
    assign hi = ~k + SHW'(1);

    assign res = (op == OP_ROR) ? rr :
                 (op == OP_ROL) ? rl :
                 (op == OP_SRL) ? data >> k :
                 (op == OP_SLL) ? data << k :
                 (op == OP_SRA) ? WIDTH'($signed(data) >>> k) : data;

    // left-moving ops lose bits from the MSB end, the rest from the LSB end
    assign bit_out = (k == '0) ? 1'b0 :
                     (op == OP_ROL || op == OP_SLL) ? data[hi] : data[lo];

endmodule

// File: rtl/nbit_seq_shifter.sv
// nbit_seq_shifter: multi-cycle rotate/shift unit moving up to STEP bits per clock
module nbit_seq_shifter
    import nbit_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_err
);

    localparam logic [SHW-1:0] STEP_A = SHW'(STEP);

    state_e           state, nxt;
    logic [WIDTH-1:0] data_q, step_res;
    logic [SHW-1:0]   rem, k;
    logic [2:0]       op_q;
    logic             carry_q, err_q, step_bit, reserved;

    assign reserved = in_op > OP_SRA;
    assign k        = (rem < STEP_A) ? rem : STEP_A;

    nbit_step_shift #(.WIDTH(WIDTH), .STEP(STEP), .SHW(SHW)) u_step (
        .data   (data_q),
        .k      (k),
        .op     (op_q),
        .res    (step_res),
        .bit_out(step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: nxt = !in_valid ? ST_IDLE : (in_amt == '0 || reserved) ? ST_DONE : ST_RUN;
            ST_RUN:  nxt = (rem == k) ? ST_DONE : ST_RUN;
            ST_DONE: nxt = out_ready ? ST_IDLE : ST_DONE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == ST_IDLE;
        out_valid = state == ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rem     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            data_q  <= in_data;
            rem     <= in_amt;
            op_q    <= in_op;
            carry_q <= 1'b0;
            err_q   <= reserved;
        end else if (state == ST_RUN) begin
            data_q  <= step_res;
            carry_q <= step_bit;
            rem     <= rem - k;
        end
    end

    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_err   = err_q;

endmodule
